// File: rtl/line_frame_counter_pkg.sv
// Package for the 2-D raster timing counter.
// Holds the FSM state encoding and the default widths and terminal counts
// shared by the interface, the counter sub-module and the top.
package lfc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned LFC_H_WIDTH     = 12;
    localparam int unsigned LFC_V_WIDTH     = 11;
    localparam int unsigned LFC_H_LAST_NORM = 1289;
    localparam int unsigned LFC_H_LAST_TEST = 4095;
    localparam int unsigned LFC_V_LAST_NORM = 1023;
    localparam int unsigned LFC_V_LAST_TEST = 2047;

endpackage

// File: rtl/line_frame_counter_if.sv
// Control and status bundle of line_frame_counter.
// Control (driven by the master): enb, test, hold, oneshot.
// Status (driven by the counter): h_count, v_count, end_line, end_frame,
//   frame_done, busy, mode.
interface line_frame_counter_if
    import lfc_pkg::*;
#(
    parameter int unsigned H_WIDTH = LFC_H_WIDTH,
    parameter int unsigned V_WIDTH = LFC_V_WIDTH
) ();

    logic               enb;
    logic               test;
    logic               hold;
    logic               oneshot;
    logic [H_WIDTH-1:0] h_count;
    logic [V_WIDTH-1:0] v_count;
    logic               end_line;
    logic               end_frame;
    logic               frame_done;
    logic               busy;
    logic               mode;

    modport master (
        output enb, test, hold, oneshot,
        input  h_count, v_count, end_line, end_frame, frame_done, busy, mode
    );

    modport slave (
        input  enb, test, hold, oneshot,
        output h_count, v_count, end_line, end_frame, frame_done, busy, mode
    );

endinterface

// File: rtl/line_frame_counter_counter.sv
// mod_counter: wrapping up-counter with a run-time terminal value.
// Ports: clk, rst_n; clear_i (sync clear, wins over inc_i); inc_i (advance);
//   last_i (terminal value); count_o (registered count);
//   at_last_c_o (count_o == last_i, decoded from the register).
// The wrap to zero is explicit at last_i, so an all-ones terminal value never
// depends on natural overflow.
module mod_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] count_o,
    output logic         at_last_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_last_c_o = (count_q == last_i);
    assign count_o     = count_q;

    // Next count: clear, wrap at terminal value, or increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = at_last_c_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/line_frame_counter.sv
// line_frame_counter: 2-D raster timing generator (pixel counter nested in a
// line counter) with hold, one-shot frame mode and a frame-done pulse.
// Ports: clk, rst_n (async, active low);
//   bus (slave): enb, test, hold, oneshot in;
//   h_count, v_count, end_line, end_frame, frame_done, busy, mode out.
// end_line/end_frame are decoded from registers only; frame_done is
// registered. Terminal counts follow the latched mode, never the live test.
module line_frame_counter
    import lfc_pkg::*;
#(
    parameter int unsigned H_WIDTH     = LFC_H_WIDTH,
    parameter int unsigned V_WIDTH     = LFC_V_WIDTH,
    parameter int unsigned H_LAST_NORM = LFC_H_LAST_NORM,
    parameter int unsigned H_LAST_TEST = LFC_H_LAST_TEST,
    parameter int unsigned V_LAST_NORM = LFC_V_LAST_NORM,
    parameter int unsigned V_LAST_TEST = LFC_V_LAST_TEST
) (
    input logic                  clk,
    input logic                  rst_n,
    line_frame_counter_if.slave  bus
);

    // Terminal counts must fit their counters.
    if (longint'(H_LAST_NORM) >= (longint'(1) << H_WIDTH) ||
        longint'(H_LAST_TEST) >= (longint'(1) << H_WIDTH)) begin : g_h_range_err
        $error("line_frame_counter: H_LAST_* does not fit in H_WIDTH");
    end
    if (longint'(V_LAST_NORM) >= (longint'(1) << V_WIDTH) ||
        longint'(V_LAST_TEST) >= (longint'(1) << V_WIDTH)) begin : g_v_range_err
        $error("line_frame_counter: V_LAST_* does not fit in V_WIDTH");
    end

    state_e             state_q;
    state_e             state_d;
    logic               mode_q;
    logic               mode_d;
    logic               frame_done_q;

    logic [H_WIDTH-1:0] h_last;
    logic [V_WIDTH-1:0] v_last;
    logic [H_WIDTH-1:0] h_count;
    logic [V_WIDTH-1:0] v_count;
    logic               h_at_last_c;
    logic               v_at_last_c;
    logic               h_clr;
    logic               h_inc;
    logic               v_clr;
    logic               v_inc;
    logic               end_line_c;
    logic               end_frame_c;

    // Terminal-count mux driven by the per-frame latched mode.
    assign h_last = mode_q ? H_WIDTH'(H_LAST_TEST) : H_WIDTH'(H_LAST_NORM);
    assign v_last = mode_q ? V_WIDTH'(V_LAST_TEST) : V_WIDTH'(V_LAST_NORM);

    // Strobes exist only in RUN, so a terminal count frozen by HOLD is silent.
    assign end_line_c  = (state_q == RUN) && h_at_last_c;
    assign end_frame_c = end_line_c && v_at_last_c;

    mod_counter #(.W(H_WIDTH)) u_h_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (h_clr),
        .inc_i       (h_inc),
        .last_i      (h_last),
        .count_o     (h_count),
        .at_last_c_o (h_at_last_c)
    );

    mod_counter #(.W(V_WIDTH)) u_v_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (v_clr),
        .inc_i       (v_inc),
        .last_i      (v_last),
        .count_o     (v_count),
        .at_last_c_o (v_at_last_c)
    );

    // Next state, mode latch and counter controls; enb low overrides all.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        h_clr   = 1'b0;
        h_inc   = 1'b0;
        v_clr   = 1'b0;
        v_inc   = 1'b0;

        if (state_q == IDLE) begin
            mode_d = bus.test;
        end

        if (!bus.enb) begin
            state_d = IDLE;
            h_clr   = 1'b1;
            v_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                    h_clr   = 1'b1;
                    v_clr   = 1'b1;
                end
                RUN: begin
                    if (bus.hold) begin
                        state_d = HOLD;
                    end else begin
                        h_inc = 1'b1;
                        v_inc = h_at_last_c;
                        // Both counters wrap on their own at end of frame.
                        if (end_frame_c) begin
                            mode_d = bus.test;
                            if (bus.oneshot) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!bus.hold) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    h_clr = 1'b1;
                    v_clr = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    h_clr   = 1'b1;
                    v_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            frame_done_q <= end_frame_c;
        end
    end

    assign bus.h_count    = h_count;
    assign bus.v_count    = v_count;
    assign bus.end_line   = end_line_c;
    assign bus.end_frame  = end_frame_c;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == RUN) || (state_q == HOLD);
    assign bus.mode       = mode_q;

endmodule

// File: tb/tb_line_frame_counter.sv
// Directed self-checking bench for line_frame_counter with small parameters.
module tb_line_frame_counter;

    localparam int unsigned HW  = 4;
    localparam int unsigned VW  = 3;
    localparam int          HLN = 5;
    localparam int          HLT = 15;
    localparam int          VLN = 2;
    localparam int          VLT = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    line_frame_counter_if #(.H_WIDTH(HW), .V_WIDTH(VW)) lfc_if ();

    line_frame_counter #(
        .H_WIDTH     (HW),
        .V_WIDTH     (VW),
        .H_LAST_NORM (HLN),
        .H_LAST_TEST (HLT),
        .V_LAST_NORM (VLN),
        .V_LAST_TEST (VLT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lfc_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int fd_exp, input int mode_exp);
        chk({tag, " h"},          32'(lfc_if.h_count),    0);
        chk({tag, " v"},          32'(lfc_if.v_count),    0);
        chk({tag, " end_line"},   32'(lfc_if.end_line),   0);
        chk({tag, " end_frame"},  32'(lfc_if.end_frame),  0);
        chk({tag, " busy"},       32'(lfc_if.busy),       0);
        chk({tag, " frame_done"}, 32'(lfc_if.frame_done), 32'(fd_exp));
        chk({tag, " mode"},       32'(lfc_if.mode),       32'(mode_exp));
    endtask

    // Expected raster position for RUN cycle n (n=0 is the first RUN cycle).
    task automatic step_check(input string tag, input int n, input int hl,
                              input int vl, input int mode_exp);
        int fl;
        int h;
        int v;
        string t;
        fl = (hl + 1) * (vl + 1);
        h  = n % (hl + 1);
        v  = (n / (hl + 1)) % (vl + 1);
        t  = $sformatf("%s n=%0d", tag, n);
        chk({t, " h"},          32'(lfc_if.h_count),    32'(h));
        chk({t, " v"},          32'(lfc_if.v_count),    32'(v));
        chk({t, " end_line"},   32'(lfc_if.end_line),   32'(h == hl));
        chk({t, " end_frame"},  32'(lfc_if.end_frame),  32'(h == hl && v == vl));
        chk({t, " frame_done"}, 32'(lfc_if.frame_done), 32'(n > 0 && n % fl == 0));
        chk({t, " busy"},       32'(lfc_if.busy),       1);
        chk({t, " mode"},       32'(lfc_if.mode),       32'(mode_exp));
    endtask

    task automatic run(input string tag, input int n0, input int n1, input int hl,
                       input int vl, input int mode_exp);
        for (int n = n0; n <= n1; n++) begin
            tick();
            step_check(tag, n, hl, vl, mode_exp);
        end
    endtask

    initial begin
        lfc_if.enb     = 1'b0;
        lfc_if.test    = 1'b0;
        lfc_if.hold    = 1'b0;
        lfc_if.oneshot = 1'b0;

        // Reset state
        tick();
        tick();
        check_idle("reset", 0, 0);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 0, 0);

        // Normal free-run: 6-clk lines, 18-clk frames
        lfc_if.enb = 1'b1;
        run("norm", 0, 39, HLN, VLN, 0);
        lfc_if.enb = 1'b0;
        tick();
        check_idle("norm_stop", 0, 0);

        // Test mode with all-ones h terminal: 16-clk lines, 128-clk frames
        lfc_if.test = 1'b1;
        tick();
        chk("test_mode_latched", 32'(lfc_if.mode), 1);
        lfc_if.enb = 1'b1;
        run("test", 0, 129, HLT, VLT, 1);
        lfc_if.enb = 1'b0;
        tick();
        check_idle("test_stop", 0, 1);
        lfc_if.test = 1'b0;
        tick();
        chk("mode_back_norm", 32'(lfc_if.mode), 0);

        // Mode latch: toggle test at h=3,v=1; takes effect next frame
        lfc_if.enb = 1'b1;
        run("latch_a", 0, 9, HLN, VLN, 0);
        lfc_if.test = 1'b1;
        run("latch_b", 10, 17, HLN, VLN, 0);
        tick();
        chk("latch_new_h",     32'(lfc_if.h_count),    0);
        chk("latch_new_v",     32'(lfc_if.v_count),    0);
        chk("latch_new_mode",  32'(lfc_if.mode),       1);
        chk("latch_new_fdone", 32'(lfc_if.frame_done), 1);
        chk("latch_new_eline", 32'(lfc_if.end_line),   0);
        run("latch_c", 1, 20, HLT, VLT, 1);
        lfc_if.enb = 1'b0;
        tick();
        check_idle("latch_stop", 0, 1);
        lfc_if.test = 1'b0;
        tick();

        // Hold for 4 clks on the terminal pixel
        lfc_if.enb = 1'b1;
        run("hold_pre", 0, 5, HLN, VLN, 0);
        lfc_if.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold%0d h", i),         32'(lfc_if.h_count),   5);
            chk($sformatf("hold%0d v", i),         32'(lfc_if.v_count),   0);
            chk($sformatf("hold%0d end_line", i),  32'(lfc_if.end_line),  0);
            chk($sformatf("hold%0d end_frame", i), 32'(lfc_if.end_frame), 0);
            chk($sformatf("hold%0d busy", i),      32'(lfc_if.busy),      1);
        end
        lfc_if.hold = 1'b0;
        tick();
        chk("resume h",        32'(lfc_if.h_count),  5);
        chk("resume end_line", 32'(lfc_if.end_line), 1);
        run("hold_post", 6, 8, HLN, VLN, 0);
        lfc_if.enb = 1'b0;
        tick();
        check_idle("hold_stop", 0, 0);

        // One-shot: single 18-clk frame then DONE
        lfc_if.oneshot = 1'b1;
        lfc_if.enb     = 1'b1;
        run("oneshot", 0, 17, HLN, VLN, 0);
        tick();
        check_idle("done_entry", 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("done%0d", i), 0, 0);
        end
        lfc_if.enb     = 1'b0;
        lfc_if.oneshot = 1'b0;
        tick();
        check_idle("done_exit", 0, 0);

        // enb low while in HOLD returns to IDLE with cleared counters
        lfc_if.enb = 1'b1;
        run("stop_pre", 0, 3, HLN, VLN, 0);
        lfc_if.hold = 1'b1;
        tick();
        chk("stop_hold h",    32'(lfc_if.h_count), 3);
        chk("stop_hold busy", 32'(lfc_if.busy),    1);
        lfc_if.enb = 1'b0;
        tick();
        check_idle("stop_in_hold", 0, 0);
        lfc_if.hold = 1'b0;

        // Asynchronous reset mid-line, away from the clock edge
        lfc_if.enb = 1'b1;
        run("arst_pre", 0, 8, HLN, VLN, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("arst_now", 0, 0);
        tick();
        check_idle("arst_held", 0, 0);
        rst_n = 1'b1;
        run("arst_post", 0, 7, HLN, VLN, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
